mdu_issue_ctrl: RTL and testbench
=================================

# mdu_issue_ctrl

Issue controller in the E stage, directly upstream of the multiply/divide unit (MDU). It decodes the E-stage MDU operation and drives the MDU's `start`/`op`/operand inputs, and it stalls the pipeline while an MDU operation is in flight. It also returns HI/LO for `mfhi`/`mflo` with zero added latency. A cycle counter cross-checks the MDU's `busy` against the expected latency, and the block keeps issue and stall performance counters.

## Interface
Parameters:
- `MUL_LAT`, 5: cycles `mdu_busy` stays high after a mult/multu start.
- `DIV_LAT`, 10: cycles `mdu_busy` stays high after a div/divu start.
- `WD_SLACK`, 2: extra cycles tolerated before the watchdog fires.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `e_valid`  in  1  E stage holds a valid instruction
- `e_op`  in  4  MDUOp of the E-stage instruction: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
- `e_flush`  in  1  E-stage instruction cancelled (exception/interrupt)
- `e_rs`, `e_rt`  in  32  forwarded operands
- `mdu_busy`  in  1  MDU busy
- `mdu_hi`, `mdu_lo`  in  32  MDU HI/LO registers
- `mdu_start`  out  1  start pulse to MDU
- `mdu_op`  out  4  op to MDU
- `mdu_a`, `mdu_b`  out  32  operands to MDU
- `stall`  out  1  freeze F/D/E; bubble into M
- `mf_data`  out  32  `mfhi`/`mflo` result for the E-stage result mux
- `wd_err`  out  1  sticky latency violation
- `issue_cnt`, `stall_cnt`  out  32  performance counters

## Operation
- Define `is_md = e_valid & (e_op in 1..8)` and `req = is_md & ~e_flush`.
- `stall = req & (state==BUSY | mdu_busy)`.
- Non-MDU instructions never stall.
- `mdu_start = req & ~stall`.
- `mdu_op = e_op`, `mdu_a = e_rs`, `mdu_b = e_rt`, passed straight through.
- `e_flush` suppresses `mdu_start` in the same cycle.
- An operation already started is not aborted, because the MDU has no cancel. The flush only affects the instruction presented in that cycle.
- FSM:
  - IDLE → BUSY on `mdu_start` with op 1–4. The register `exp_lat` loads `MUL_LAT` for ops 1–2 or `DIV_LAT` for ops 3–4.
  - In IDLE, ops 5–8 issue without leaving IDLE.
  - BUSY → IDLE when `cnt >= exp_lat` and `mdu_busy==0`.
- `cnt` (5 bits) clears on entry to BUSY and increments each BUSY cycle, saturating at 31.
- Watchdog: in BUSY, `wd_err` sets if `mdu_busy` is still 1 with `cnt > exp_lat+WD_SLACK`, or if `mdu_busy` is 0 at `cnt==1`. `wd_err` is sticky until reset and does not alter stalling.
- `mf_data = (e_op==5) ? mdu_hi : mdu_lo`, combinational. It is valid only when `req & ~stall`; otherwise it is 0.
- `issue_cnt` increments on every `mdu_start`.
- `stall_cnt` increments on every cycle with `stall`=1.
- Both counters wrap modulo 2^32.

## Timing
- Reset:
  - state IDLE, `cnt`=0, `exp_lat`=0, `wd_err`=0, both counters 0.
  - `stall`, `mdu_start` and `mf_data` are 0 while `reset` is high, gated regardless of inputs.
- Mult issued at cycle t:
  - MDU busy at t+1..t+5.
  - A dependent MDU op at t+1..t+5 stalls.
  - It issues at t+6.
- Div issued at cycle t: the next MDU op stalls t+1..t+10 and issues at t+11.
- Back-to-back `mthi` at t then `mfhi` at t+1: no stall; `mf_data` = value written at t.
- `mflo` while BUSY: stalls until IDLE, then returns the new LO in the first unstalled cycle.
- Flush in a stalled cycle: `stall` drops the same cycle, nothing issues, and the FSM stays in BUSY.
- Reset mid-BUSY: controller returns to IDLE next edge, and the MDU resets on the same edge.

## Structure
- Package `mdu_pkg`:
  - MDUOp encodings 0–8 as named constants.
  - `MUL_LAT`/`DIV_LAT` defaults.
  - FSM state typedef {IDLE, BUSY}.
  - `is_muldiv(op)` and `op_latency(op)` functions.
- Sub-module `mdu_lat_watchdog` contains `cnt`, `exp_lat` and the `wd_err` logic, with inputs `clear`, `lat`, `busy`, `active`.
- Performance counters stay inline.

## Test plan
- Reset with `e_valid`=1, `e_op`=1 → `mdu_start`=0, `stall`=0, counters 0; after release the first cycle issues, `issue_cnt`=1.
- `mult` (`e_rs`=3, `e_rt`=−2) at t=0, `mfhi` held from t=1 → `stall`=1 for t=1..5, `mf_data`=0xFFFFFFFF at t=6, `stall_cnt`=5.
- `divu` 100/7 at t=0, `mtlo` held from t=1 → stalls t=1..10, `mdu_start` at t=11 with `mdu_a`=value, `issue_cnt`=2.
- `div` at t=0, `addu` (`e_op`=0) at t=1..3 → `stall`=0 throughout, no `mdu_start`.
- `mult` presented with `e_flush`=1 → `mdu_start`=0, FSM stays IDLE, `issue_cnt` unchanged.
- Mock MDU holds `mdu_busy` 9 cycles after a mult (`MUL_LAT`=5, `WD_SLACK`=2) → `wd_err`=1 at BUSY cycle 8, stays 1 until reset; stall persists until `mdu_busy` drops.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the MDU issue controller: op encodings, default
// latencies, FSM state type and op classification helpers.
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  typedef enum logic {IDLE, BUSY} mdu_state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_DIVU);
  endfunction

  function automatic logic [4:0] op_latency(input logic [3:0] op, input int mul_lat,
                                            input int div_lat);
    return ((op == OP_MULT) || (op == OP_MULTU)) ? 5'(mul_lat) : 5'(div_lat);
  endfunction

endpackage

// File: rtl/mdu_lat_watchdog.sv
// Tracks how long the current mult/div has been in flight and flags an MDU
// whose busy flag disagrees with the expected latency.
module mdu_lat_watchdog
  import mdu_pkg::*;
#(
  parameter int WD_SLACK = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [4:0] lat,
  input  logic       busy,
  input  logic       active,
  output logic [4:0] cnt,
  output logic [4:0] exp_lat,
  output logic       wd_err
);

  logic [4:0] cnt_q, cnt_d;
  logic [4:0] exp_lat_q, exp_lat_d;
  logic       wd_err_q, wd_err_d;
  logic [5:0] late_limit;
  logic       too_late, too_early;

  // cnt is the 1-based index of the current BUSY cycle, so the first
  // BUSY cycle reads 1 and the MDU must already report busy there.
  always_comb begin
    cnt_d     = cnt_q;
    exp_lat_d = exp_lat_q;
    if (clear) begin
      cnt_d     = 5'd1;
      exp_lat_d = lat;
    end else if (active && (cnt_q != 5'd31)) begin
      cnt_d = cnt_q + 5'd1;
    end
  end

  assign late_limit = {1'b0, exp_lat_q} + 6'(WD_SLACK);
  assign too_late   = busy && ({1'b0, cnt_q} > late_limit);
  assign too_early  = !busy && (cnt_q == 5'd1);

  always_comb begin
    wd_err_d = wd_err_q;
    if (active && (too_late || too_early)) begin
      wd_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 5'd0;
      exp_lat_q <= 5'd0;
      wd_err_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      exp_lat_q <= exp_lat_d;
      wd_err_q  <= wd_err_d;
    end
  end

  assign cnt     = cnt_q;
  assign exp_lat = exp_lat_q;
  assign wd_err  = wd_err_q;

endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage issue/stall control for the multiply/divide unit, with zero-latency
// HI/LO readback, latency watchdog and issue/stall performance counters.
module mdu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_LAT  = MUL_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int WD_SLACK = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_op,
  input  logic        e_flush,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        mdu_busy,
  input  logic [31:0] mdu_hi,
  input  logic [31:0] mdu_lo,
  output logic        mdu_start,
  output logic [3:0]  mdu_op,
  output logic [31:0] mdu_a,
  output logic [31:0] mdu_b,
  output logic        stall,
  output logic [31:0] mf_data,
  output logic        wd_err,
  output logic [31:0] issue_cnt,
  output logic [31:0] stall_cnt
);

  mdu_state_e  state_q, state_d;
  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        is_md, req, start_md, lat_done, busy_hold;
  logic [4:0]  cnt, exp_lat;

  assign is_md    = e_valid && (e_op >= OP_MULT) && (e_op <= OP_MTLO);
  assign req      = is_md && !e_flush;
  assign lat_done = (cnt >= exp_lat) && !mdu_busy;

  // BUSY lets go in the very cycle its exit condition holds, so a waiting
  // op issues there rather than one cycle later.
  assign busy_hold = (state_q == BUSY) && !lat_done;

  assign stall     = !reset && req && (busy_hold || mdu_busy);
  assign mdu_start = !reset && req && !stall;
  assign start_md  = mdu_start && is_muldiv(e_op);

  assign mdu_op = e_op;
  assign mdu_a  = e_rs;
  assign mdu_b  = e_rt;

  assign mf_data = mdu_start ? ((e_op == OP_MFHI) ? mdu_hi : mdu_lo) : 32'd0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_md) state_d = BUSY;
      BUSY: begin
        if (start_md)      state_d = BUSY;
        else if (lat_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    issue_cnt_d = issue_cnt_q + 32'(mdu_start);
    stall_cnt_d = stall_cnt_q + 32'(stall);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      issue_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  mdu_lat_watchdog #(
    .WD_SLACK (WD_SLACK)
  ) u_wd (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_md),
    .lat     (op_latency(e_op, MUL_LAT, DIV_LAT)),
    .busy    (mdu_busy),
    .active  (state_q == BUSY),
    .cnt     (cnt),
    .exp_lat (exp_lat),
    .wd_err  (wd_err)
  );

  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl: a mock MDU reacts to the DUT, and a
// cycle-indexed reference model predicts every output.
module tb_mdu_issue_ctrl;

  localparam int MUL_LAT  = 5;
  localparam int DIV_LAT  = 10;
  localparam int WD_SLACK = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        e_valid = 1'b0;
  logic [3:0]  e_op = 4'd0;
  logic        e_flush = 1'b0;
  logic [31:0] e_rs = 32'd0;
  logic [31:0] e_rt = 32'd0;
  logic        mdu_busy;
  logic [31:0] mdu_hi = 32'd0;
  logic [31:0] mdu_lo = 32'd0;
  logic        mdu_start;
  logic [3:0]  mdu_op;
  logic [31:0] mdu_a, mdu_b;
  logic        stall;
  logic [31:0] mf_data;
  logic        wd_err;
  logic [31:0] issue_cnt, stall_cnt;

  mdu_issue_ctrl #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .WD_SLACK(WD_SLACK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .e_valid  (e_valid),
    .e_op     (e_op),
    .e_flush  (e_flush),
    .e_rs     (e_rs),
    .e_rt     (e_rt),
    .mdu_busy (mdu_busy),
    .mdu_hi   (mdu_hi),
    .mdu_lo   (mdu_lo),
    .mdu_start(mdu_start),
    .mdu_op   (mdu_op),
    .mdu_a    (mdu_a),
    .mdu_b    (mdu_b),
    .stall    (stall),
    .mf_data  (mf_data),
    .wd_err   (wd_err),
    .issue_cnt(issue_cnt),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // HI/LO result of an MDU operation, as {hi, lo}
  function automatic logic [63:0] md_exec(input logic [3:0] op, input logic [31:0] a, b,
                                          input logic [31:0] hi, lo);
    logic signed [63:0] sp;
    logic signed [31:0] sa, sb;
    logic [63:0] r;
    sa = a;
    sb = b;
    r = {hi, lo};
    case (op)
      4'd1: begin sp = 64'(sa) * 64'(sb); r = sp; end
      4'd2: r = {32'd0, a} * {32'd0, b};
      4'd3: begin
        if (b == 32'd0) r = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'd0, a};
        else r = {32'(sa % sb), 32'(sa / sb)};
      end
      4'd4: begin
        if (b == 32'd0) r = {a, 32'hFFFFFFFF};
        else r = {a % b, a / b};
      end
      4'd7: r = {a, lo};
      4'd8: r = {hi, a};
      default: r = {hi, lo};
    endcase
    return r;
  endfunction

  // Mock MDU: busy for the op latency plus a bench-chosen extra stretch
  int busy_rem = 0;
  int extra_next = 0;
  assign mdu_busy = (busy_rem != 0);

  always @(posedge clk) begin
    if (reset) begin
      busy_rem <= 0;
      mdu_hi   <= 32'd0;
      mdu_lo   <= 32'd0;
    end else if (mdu_start) begin
      {mdu_hi, mdu_lo} <= md_exec(mdu_op, mdu_a, mdu_b, mdu_hi, mdu_lo);
      if (mdu_op >= 4'd1 && mdu_op <= 4'd4)
        busy_rem <= ((mdu_op <= 4'd2) ? MUL_LAT : DIV_LAT) + extra_next;
    end else if (busy_rem != 0) begin
      busy_rem <= busy_rem - 1;
    end
  end

  typedef struct {
    logic        stall;
    logic        start;
    logic [31:0] mf;
    logic [31:0] ic;
    logic [31:0] sc;
    logic        wd;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int failures = 0;

  // Reference model: the MDU is free again from cycle m_ready onward
  int          cyc = 0;
  int          m_ready = 0;
  int          m_fire = -1;
  logic [31:0] m_ic = 0, m_sc = 0, m_hi = 0, m_lo = 0;
  logic        m_wd = 0;

  task automatic drive(input logic rst, input logic v, input logic [3:0] op, input logic fl,
                       input logic [31:0] rs, input logic [31:0] rt, input int extra);
    exp_t e;
    logic req, st, go;
    int lat, blen;
    @(negedge clk);
    reset = rst; e_valid = v; e_op = op; e_flush = fl; e_rs = rs; e_rt = rt;
    extra_next = extra;
    e.ic = m_ic; e.sc = m_sc; e.wd = m_wd; e.op = op; e.a = rs; e.b = rt; e.cyc = cyc;
    if (rst) begin
      e.stall = 0; e.start = 0; e.mf = 0;
      m_ic = 0; m_sc = 0; m_wd = 0; m_hi = 0; m_lo = 0;
      m_ready = cyc + 1; m_fire = -1;
    end else begin
      req = v && (op >= 4'd1) && (op <= 4'd8) && !fl;
      st  = req && (cyc < m_ready);
      go  = req && !st;
      e.stall = st; e.start = go;
      e.mf = go ? ((op == 4'd5) ? m_hi : m_lo) : 32'd0;
      if (m_fire == cyc) m_wd = 1;
      if (st) m_sc = m_sc + 1;
      if (go) begin
        m_ic = m_ic + 1;
        {m_hi, m_lo} = md_exec(op, rs, rt, m_hi, m_lo);
        if (op <= 4'd4) begin
          lat = (op <= 4'd2) ? MUL_LAT : DIV_LAT;
          blen = lat + extra;
          m_ready = cyc + blen + 1;
          m_fire = (blen >= lat + WD_SLACK + 1) ? cyc + lat + WD_SLACK + 1 : -1;
        end
      end
    end
    sb_q.push_back(e);
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp, input int c);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("stall", 32'(stall), 32'(e.stall), e.cyc);
        chk("mdu_start", 32'(mdu_start), 32'(e.start), e.cyc);
        chk("mf_data", mf_data, e.mf, e.cyc);
        chk("issue_cnt", issue_cnt, e.ic, e.cyc);
        chk("stall_cnt", stall_cnt, e.sc, e.cyc);
        chk("wd_err", 32'(wd_err), 32'(e.wd), e.cyc);
        if (e.start) begin
          chk("mdu_op", 32'(mdu_op), 32'(e.op), e.cyc);
          chk("mdu_a", mdu_a, e.a, e.cyc);
          chk("mdu_b", mdu_b, e.b, e.cyc);
        end
      end
    end
  end

  initial begin : stim
    logic [3:0] op;
    int r;
    // reset held with a mult presented, then the first free cycle issues it
    repeat (3) drive(1, 1, 4'd1, 0, 32'd5, 32'd6, 0);
    drive(0, 1, 4'd1, 0, 32'd5, 32'd6, 0);
    repeat (8) drive(0, 0, 4'd0, 0, 32'd0, 32'd0, 0);
    // mult 3 * -2, then mfhi waits for it
    drive(0, 1, 4'd1, 0, 32'd3, 32'hFFFFFFFE, 0);
    repeat (6) drive(0, 1, 4'd5, 0, 32'd0, 32'd0, 0);
    // divu 100/7, then mtlo waits through the full divide latency
    drive(0, 1, 4'd4, 0, 32'd100, 32'd7, 0);
    repeat (11) drive(0, 1, 4'd8, 0, 32'hCAFE0001, 32'd0, 0);
    drive(0, 1, 4'd6, 0, 32'd0, 32'd0, 0);
    // div followed by non-MDU instructions: no stall
    drive(0, 1, 4'd3, 0, 32'hFFFFFF9C, 32'd7, 0);
    repeat (3) drive(0, 1, 4'd0, 0, 32'd1, 32'd2, 0);
    repeat (8) drive(0, 0, 4'd0, 0, 32'd0, 32'd0, 0);
    // flushed mult never issues
    drive(0, 1, 4'd1, 1, 32'd9, 32'd9, 0);
    drive(0, 1, 4'd6, 0, 32'd0, 32'd0, 0);
    // mthi then mfhi back to back
    drive(0, 1, 4'd7, 0, 32'h0BADF00D, 32'd0, 0);
    drive(0, 1, 4'd5, 0, 32'd0, 32'd0, 0);
    // flush in a stalled cycle, then the slow MDU trips the watchdog
    drive(0, 1, 4'd1, 0, 32'd7, 32'd8, 4);
    drive(0, 1, 4'd5, 1, 32'd0, 32'd0, 0);
    repeat (12) drive(0, 1, 4'd5, 0, 32'd0, 32'd0, 0);
    repeat (4) drive(0, 1, 4'd0, 0, 32'd0, 32'd0, 0);
    // reset in the middle of a divide
    drive(0, 1, 4'd3, 0, 32'd50, 32'd3, 0);
    repeat (3) drive(0, 1, 4'd6, 0, 32'd0, 32'd0, 0);
    drive(1, 1, 4'd6, 0, 32'd0, 32'd0, 0);
    drive(0, 1, 4'd6, 0, 32'd0, 32'd0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      op = (r < 85) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), op,
            ($urandom_range(0, 9) == 0), $urandom, $urandom,
            ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : 0);
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
